regfile_mp: RTL and testbench

//  Parametrised integer register file for the multicycle RISC-V core and its successors.
//  - Any number of read ports; one write port with byte enables.
//  - x0 is hardwired to zero.
//  - Optional write-to-read bypass and optional registered (1-cycle) reads.
//  - A sequential clear engine zeroes the array after reset or on request, and flags busy while it runs.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_mp_if.sv | 27 ++
 rtl/regfile_rdport.sv | 45 ++++
 rtl/regfile_mp.sv | 85 ++++++++
 tb/tb_regfile_mp.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and the byte-enable merge for the register file
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  // Widest data path rf_merge handles; callers cast their XLEN-wide values in and out.
  localparam int RF_MAXW = 64;
  localparam int RF_MAXB = RF_MAXW / 8;

  // Bytes with be set come from new_v, all others keep old_v.
  function automatic logic [RF_MAXW-1:0] rf_merge(input logic [RF_MAXW-1:0] old_v,
                                                  input logic [RF_MAXW-1:0] new_v,
                                                  input logic [RF_MAXB-1:0] be);
    logic [RF_MAXW-1:0] r;
    r = old_v;
    for (int b = 0; b < RF_MAXB; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/clear bus between datapath and register file
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic [XLEN/8-1:0]   wbe;
  logic                clear_req;
  logic                busy;

  modport master (
    output rd_addr, we, wa, wd, wbe, clear_req,
    input  rd_data, busy
  );

  modport slave (
    input  rd_addr, we, wa, wd, wbe, clear_req,
    output rd_data, busy
  );
endinterface

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one read channel: x0 mask, write bypass, optional output register
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int RD_LAT = 0,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              busy,
  input  logic [AW-1:0]     addr,
  input  logic [XLEN-1:0]   mem_word,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [XLEN-1:0]   wd,
  input  logic [XLEN/8-1:0] wbe,
  output logic [XLEN-1:0]   data
);
  logic [XLEN-1:0] comb_data;
  logic [XLEN-1:0] data_q;
  logic            hit;

  assign hit = (BYPASS != 0) && !busy && we && (wa == addr) && (addr != '0);

  // Zero-latency view: zero while clearing or for x0, forwarded write data on a bypass hit.
  always_comb begin
    comb_data = '0;
    if (!busy && addr != '0) begin
      if (hit)
        comb_data = XLEN'(rf_merge(RF_MAXW'(mem_word), RF_MAXW'(wd), RF_MAXB'(wbe)));
      else
        comb_data = mem_word;
    end
  end

  // Registered copy of the zero-latency view, used only when RD_LAT is 1.
  always_ff @(posedge clk) begin
    if (reset) data_q <= '0;
    else       data_q <= comb_data;
  end

  assign data = (RD_LAT != 0) ? data_q : comb_data;
endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port integer register file with byte-enable writes and clear engine
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int RD_LAT = 0,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  rf_state_e           state;
  logic [AW-1:0]       ptr;
  logic                busy_q;
  logic                wr_en;
  logic [XLEN-1:0]     mem [1:NREGS-1];
  logic [NRD*XLEN-1:0] rd_all;

  assign bus.busy    = busy_q;
  assign bus.rd_data = rd_all;
  assign wr_en       = !reset && !busy_q && bus.we && (bus.wa != '0);

  // Clear engine: reset or clear_req (re)starts a sweep from entry 1; the sweep ends after entry NREGS-1.
  always_ff @(posedge clk) begin
    if (reset || bus.clear_req) begin
      state  <= RF_CLEAR;
      ptr    <= AW'(1);
      busy_q <= 1'b1;
    end else if (state == RF_CLEAR) begin
      ptr <= ptr + AW'(1);
      if (ptr == AW'(NREGS - 1)) begin
        state  <= RF_IDLE;
        busy_q <= 1'b0;
      end
    end
  end

  // Storage: the clear sweep zeroes one entry per cycle; otherwise the write port merges enabled bytes.
  always_ff @(posedge clk) begin
    for (int j = 1; j < NREGS; j++) begin
      if (state == RF_CLEAR && ptr == AW'(j))
        mem[j] <= '0;
      else if (wr_en && bus.wa == AW'(j))
        mem[j] <= XLEN'(rf_merge(RF_MAXW'(mem[j]), RF_MAXW'(bus.wd), RF_MAXB'(bus.wbe)));
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] word;

    assign addr = bus.rd_addr[i*AW +: AW];

    // Array lookup for this port; x0 has no storage and looks up as zero.
    always_comb begin
      word = '0;
      for (int j = 1; j < NREGS; j++) begin
        if (addr == AW'(j)) word = mem[j];
      end
    end

    regfile_rdport #(
      .XLEN   (XLEN),
      .AW     (AW),
      .RD_LAT (RD_LAT),
      .BYPASS (BYPASS)
    ) u_rdport (
      .clk      (clk),
      .reset    (reset),
      .busy     (busy_q),
      .addr     (addr),
      .mem_word (word),
      .we       (bus.we),
      .wa       (bus.wa),
      .wd       (bus.wd),
      .wbe      (bus.wbe),
      .data     (rd_all[i*XLEN +: XLEN])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed scoreboard bench for three regfile_mp configurations
module tb_regfile_mp;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus0 ();
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus1 ();
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus2 ();

  // dut0: combinational + bypass, dut1: combinational no bypass, dut2: registered + bypass
  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .RD_LAT(0), .BYPASS(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .RD_LAT(0), .BYPASS(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .RD_LAT(1), .BYPASS(1)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  typedef struct {
    int          which;
    int          port;
    logic [31:0] exp;
    int          due;
    string       tag;
  } sb_t;

  sb_t         sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  bit          chk_en = 1'b0;
  logic [31:0] m_mem [32];
  int          m_left;
  string       cur_tag = "init";

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] get_obs(input int w, input int p);
    logic [31:0] v;
    case (w)
      0:       v = (p == 2) ? {31'b0, bus0.busy} : bus0.rd_data[p*32 +: 32];
      1:       v = (p == 2) ? {31'b0, bus1.busy} : bus1.rd_data[p*32 +: 32];
      default: v = (p == 2) ? {31'b0, bus2.busy} : bus2.rd_data[p*32 +: 32];
    endcase
    return v;
  endfunction

  // Scoreboard drain: compare every entry due in this cycle, half a period after the drive.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].due == cyc) begin
          logic [31:0] obs;
          obs = get_obs(sb[k].which, sb[k].port);
          n_checks++;
          assert (obs === sb[k].exp) else begin
            n_err++;
            $error("FAIL %s dut%0d port%0d cyc%0d: got %h expected %h",
                   sb[k].tag, sb[k].which, sb[k].port, cyc, obs, sb[k].exp);
          end
          sb.delete(k);
        end
      end
    end
  end

  task automatic drive(input logic clr, input logic we_i, input logic [4:0] wa_i, input logic [31:0] wd_i,
                       input logic [3:0] be_i, input logic [4:0] a0, input logic [4:0] a1);
    bus0.clear_req = clr; bus1.clear_req = clr; bus2.clear_req = clr;
    bus0.we = we_i;       bus1.we = we_i;       bus2.we = we_i;
    bus0.wa = wa_i;       bus1.wa = wa_i;       bus2.wa = wa_i;
    bus0.wd = wd_i;       bus1.wd = wd_i;       bus2.wd = wd_i;
    bus0.wbe = be_i;      bus1.wbe = be_i;      bus2.wbe = be_i;
    bus0.rd_addr = {a1, a0};
    bus1.rd_addr = {a1, a0};
    bus2.rd_addr = {a1, a0};
  endtask

  task automatic step(input logic rst, input logic clr, input logic we_i, input logic [4:0] wa_i,
                      input logic [31:0] wd_i, input logic [3:0] be_i, input logic [4:0] a0, input logic [4:0] a1);
    bit          m_busy;
    logic [4:0]  a;
    logic [31:0] plain;
    logic [31:0] byp;
    reset = rst;
    drive(clr, we_i, wa_i, wd_i, be_i, a0, a1);
    m_busy = (m_left > 0);
    for (int p = 0; p < 2; p++) begin
      a = (p == 0) ? a0 : a1;
      plain = (m_busy || a == 5'd0) ? 32'h0 : m_mem[a];
      byp = (!m_busy && we_i && wa_i == a && a != 5'd0) ? mrg(m_mem[a], wd_i, be_i) : plain;
      sb.push_back('{0, p, byp, cyc, cur_tag});
      sb.push_back('{1, p, plain, cyc, cur_tag});
      sb.push_back('{2, p, rst ? 32'h0 : byp, cyc + 1, cur_tag});
    end
    for (int w = 0; w < 3; w++) sb.push_back('{w, 2, {31'b0, m_busy}, cyc, {cur_tag, "_busy"}});
    @(posedge clk);
    if (rst) begin
      m_left = 31;
      for (int r = 0; r < 32; r++) m_mem[r] = 32'h0;
    end else if (m_left > 0) begin
      if (clr) m_left = 31;
      else     m_left--;
    end else begin
      if (we_i && wa_i != 5'd0) m_mem[wa_i] = mrg(m_mem[wa_i], wd_i, be_i);
      if (clr) begin
        m_left = 31;
        for (int r = 0; r < 32; r++) m_mem[r] = 32'h0;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    m_left = 31;
    for (int r = 0; r < 32; r++) m_mem[r] = 32'h0;
    chk_en = 1'b1;

    cur_tag = "reset_hold";
    step(1, 0, 0, 5'd0, 32'h0, 4'h0, 5'd1, 5'd2);
    cur_tag = "reset_clear";
    for (int i = 0; i < 31; i++) step(0, 0, 1, 5'd4, 32'(i + 1), 4'hF, 5'(i), 5'(31 - i));
    cur_tag = "zero_after_reset";
    for (int i = 0; i < 16; i++) step(0, 0, 0, 5'd0, 32'h0, 4'h0, 5'(2 * i), 5'(2 * i + 1));

    cur_tag = "write_read";
    step(0, 0, 1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5, 5'd0);
    step(0, 0, 0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5);
    cur_tag = "x0_write";
    step(0, 0, 1, 5'd0, 32'h00001234, 4'hF, 5'd0, 5'd0);
    step(0, 0, 0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd5);

    cur_tag = "byte_en";
    step(0, 0, 1, 5'd7, 32'h11223344, 4'hF, 5'd0, 5'd0);
    step(0, 0, 1, 5'd7, 32'hAABBCCDD, 4'b0101, 5'd7, 5'd0);
    step(0, 0, 0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd7);
    step(0, 0, 1, 5'd7, 32'h99999999, 4'h0, 5'd7, 5'd7);
    step(0, 0, 0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd5);

    cur_tag = "bypass";
    step(0, 0, 1, 5'd9, 32'h00000011, 4'hF, 5'd0, 5'd0);
    step(0, 0, 1, 5'd9, 32'h00000055, 4'hF, 5'd9, 5'd9);
    step(0, 0, 0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd9);
    step(0, 0, 1, 5'd9, 32'hAABBCCDD, 4'b0011, 5'd9, 5'd9);
    step(0, 0, 0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd7);

    cur_tag = "reg_read";
    step(0, 0, 1, 5'd3, 32'h00000077, 4'hF, 5'd0, 5'd0);
    step(0, 0, 0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd3);
    step(0, 0, 0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd0);

    cur_tag = "clear_req";
    step(0, 1, 0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd3);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 5'd4, 32'h0000CAFE, 4'hF, 5'd4, 5'd5);
    cur_tag = "clear_restart";
    step(0, 1, 1, 5'd4, 32'h0000CAFE, 4'hF, 5'd4, 5'd7);
    for (int i = 0; i < 31; i++) step(0, 0, 1, 5'd4, 32'h0000BEEF, 4'hF, 5'd4, 5'(i));
    cur_tag = "zero_after_clear";
    for (int i = 0; i < 16; i++) step(0, 0, 0, 5'd0, 32'h0, 4'h0, 5'(2 * i), 5'(2 * i + 1));

    cur_tag = "reset_in_clear";
    step(0, 0, 1, 5'd12, 32'h12345678, 4'hF, 5'd12, 5'd0);
    step(0, 1, 0, 5'd0, 32'h0, 4'h0, 5'd12, 5'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 5'd0, 32'h0, 4'h0, 5'd12, 5'd1);
    step(1, 1, 1, 5'd12, 32'hFFFFFFFF, 4'hF, 5'd12, 5'd0);
    for (int i = 0; i < 31; i++) step(0, 0, 0, 5'd0, 32'h0, 4'h0, 5'd12, 5'(31 - i));
    cur_tag = "post_reset_write";
    step(0, 0, 1, 5'd31, 32'hA5A5A5A5, 4'b1001, 5'd31, 5'd12);
    step(0, 0, 0, 5'd0, 32'h0, 4'h0, 5'd31, 5'd12);

    @(negedge clk);
    #1;
    n_checks++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
